// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register of the five-stage MIPS datapath.
// It captures decoded control, operands, immediate and register specifiers
// from ID and presents them registered to EX. It supports stall (hold) and
// flush (bubble insertion). Flush has priority over stall, which has
// priority over load.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to build a saturating 16-bit
// count of inserted bubbles. Without it, bubble_cnt is tied to zero.
module id_ex_reg #(
  parameter int bits = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [8:0]      id_ctrl,
  input  logic [bits-1:0] id_pc4,
  input  logic [bits-1:0] id_rd1,
  input  logic [bits-1:0] id_rd2,
  input  logic [bits-1:0] id_imm,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  output logic            ex_valid,
  output logic [8:0]      ex_ctrl,
  output logic [bits-1:0] ex_pc4,
  output logic [bits-1:0] ex_rd1,
  output logic [bits-1:0] ex_rd2,
  output logic [bits-1:0] ex_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [15:0]     bubble_cnt
);

  logic            valid_d, valid_q;
  logic [8:0]      ctrl_d, ctrl_q;
  logic [bits-1:0] pc4_d, pc4_q;
  logic [bits-1:0] rd1_d, rd1_q;
  logic [bits-1:0] rd2_d, rd2_q;
  logic [bits-1:0] imm_d, imm_q;
  logic [4:0]      rs_d, rs_q;
  logic [4:0]      rt_d, rt_q;
  logic [4:0]      rd_d, rd_q;

  // Next-state selection: flush loads a bubble, stall holds, otherwise load from ID.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc4_d   = pc4_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    if (flush) begin
      // Bubble: all enables cleared so EX cannot write registers or memory.
      // Data fields still load; they are don't-care to EX with ctrl zeroed.
      valid_d = 1'b0;
      ctrl_d  = 9'h000;
      pc4_d   = id_pc4;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      rs_d    = 5'd0;
      rt_d    = 5'd0;
      rd_d    = 5'd0;
    end else if (stall) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end else begin
      // An invalid ID slot carries no side effects, so its control is cleared.
      valid_d = id_valid;
      if (id_valid) begin
        ctrl_d = id_ctrl;
      end else begin
        ctrl_d = 9'h000;
      end
      pc4_d = id_pc4;
      rd1_d = id_rd1;
      rd2_d = id_rd2;
      imm_d = id_imm;
      rs_d  = id_rs;
      rt_d  = id_rt;
      rd_d  = id_rd;
    end
  end

  // Pipeline register state, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= 9'h000;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc4_q   <= pc4_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_ctrl  = ctrl_q;
  assign ex_pc4   = pc4_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_rd    = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] cnt_d, cnt_q;

  // Saturating bubble count: advances on every taken flush, never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (flush && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Bubble counter register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed self-checking bench for id_ex_reg.
// Works in both builds; the expected bubble count follows ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [8:0]  id_ctrl;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_valid;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] bubble_cnt;

  int          checks;
  int          errors;
  logic [15:0] exp_cnt;
  int          n_flush;

  id_ex_reg #(.bits(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .bubble_cnt(bubble_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 unit so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side model of the bubble counter for one taken flush.
  task automatic model_flush();
    if (CNT_EN && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic set_id(input logic v, input logic [8:0] c, input logic [31:0] pc4,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; id_ctrl = c; id_pc4 = pc4; id_rd1 = r1; id_rd2 = r2;
    id_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 16'h0000;

    // Bring the register to an all-ones state, then reset asynchronously mid-cycle.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 9'h1FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           5'h1F, 5'h1F, 5'h1F);
    #2 rst_n = 1'b1;
    tick();
    check_eq("preload_ctrl", {23'd0, ex_ctrl}, 32'h0000_01FF);
    check_eq("preload_rd1", ex_rd1, 32'hFFFF_FFFF);
    #2;
    stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_ctrl", {23'd0, ex_ctrl}, 32'd0);
    check_eq("rst_pc4", ex_pc4, 32'd0);
    check_eq("rst_rd1", ex_rd1, 32'd0);
    check_eq("rst_rd2", ex_rd2, 32'd0);
    check_eq("rst_imm", ex_imm, 32'd0);
    check_eq("rst_spec", {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    check_eq("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    tick();
    check_eq("rst_hold_ctrl", {23'd0, ex_ctrl}, 32'd0);

    // Release reset with a plain load pending; the first edge loads.
    stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 9'h1A3, 32'h0000_0104, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFF0,
           5'd3, 5'd9, 5'd12);
    rst_n = 1'b1;
    tick();
    check_eq("load_ctrl", {23'd0, ex_ctrl}, 32'h0000_01A3);
    check_eq("load_rd1", ex_rd1, 32'h0000_0005);
    check_eq("load_rt", {27'd0, ex_rt}, 32'd9);
    check_eq("load_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("load_pc4", ex_pc4, 32'h0000_0104);
    check_eq("load_rd2", ex_rd2, 32'h0000_0007);
    check_eq("load_imm", ex_imm, 32'hFFFF_FFF0);
    check_eq("load_rs_rd", {22'd0, ex_rs, ex_rd}, {22'd0, 5'd3, 5'd12});

    // Stall three cycles with new ID values: everything holds.
    stall = 1'b1;
    set_id(1'b1, 9'h0F3, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0011, 32'h0000_0022,
           5'd1, 5'd17, 5'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_rd1", ex_rd1, 32'h0000_0005);
      check_eq("stall_ctrl", {23'd0, ex_ctrl}, 32'h0000_01A3);
      check_eq("stall_rt", {27'd0, ex_rt}, 32'd9);
    end
    stall = 1'b0;
    tick();
    check_eq("release_rd1", ex_rd1, 32'hDEAD_BEEF);
    check_eq("release_ctrl", {23'd0, ex_ctrl}, 32'h0000_00F3);
    check_eq("release_rt", {27'd0, ex_rt}, 32'd17);

    // Load of an invalid slot: control cleared, specifiers load, no bubble counted.
    set_id(1'b0, 9'h1FF, 32'h0000_0300, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055,
           5'd4, 5'd5, 5'd6);
    tick();
    check_eq("inval_ctrl", {23'd0, ex_ctrl}, 32'd0);
    check_eq("inval_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("inval_rt", {27'd0, ex_rt}, 32'd5);
    check_eq("inval_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt});

    // Flush a full-control instruction: bubble loaded.
    flush = 1'b1;
    set_id(1'b1, 9'h1FF, 32'h0000_0400, 32'h1234_5678, 32'h0000_0066, 32'h0000_0077,
           5'd7, 5'd8, 5'd10);
    tick();
    model_flush();
    flush = 1'b0;
    check_eq("flush_ctrl", {23'd0, ex_ctrl}, 32'd0);
    check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("flush_spec", {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    check_eq("flush_rd1", ex_rd1, 32'h1234_5678);
    check_eq("flush_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt});

    // Stall-only: bubble and count hold.
    stall = 1'b1;
    tick();
    check_eq("stall_bub_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("stall_bub_rd1", ex_rd1, 32'h1234_5678);
    check_eq("stall_bub_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt});

    // Stall and flush together: flush wins.
    flush = 1'b1;
    id_rd1 = 32'hA5A5_A5A5;
    tick();
    model_flush();
    stall = 1'b0; flush = 1'b0;
    check_eq("both_ctrl", {23'd0, ex_ctrl}, 32'd0);
    check_eq("both_rd1", ex_rd1, 32'hA5A5_A5A5);
    check_eq("both_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt});

    // Normal load after the bubble.
    tick();
    check_eq("after_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("after_ctrl", {23'd0, ex_ctrl}, 32'h0000_01FF);
    check_eq("after_rd", {27'd0, ex_rd}, 32'd10);

    // Reset asserted mid-flush clears the count.
    flush = 1'b1;
    tick();
    model_flush();
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 16'h0000;
    check_eq("rst_flush_cnt", {16'd0, bubble_cnt}, 32'd0);
    check_eq("rst_flush_rd1", ex_rd1, 32'd0);
    tick();
    rst_n = 1'b1;

    // Long run of flushes: saturates at FFFF with the counter, stays 0 without.
    n_flush = CNT_EN ? 65540 : 8;
    for (int i = 0; i < n_flush; i++) begin
      tick();
      model_flush();
    end
    check_eq("sat_cnt", {16'd0, bubble_cnt}, {16'd0, exp_cnt});
    tick();
    model_flush();
    check_eq("sat_cnt_hold", {16'd0, bubble_cnt}, {16'd0, exp_cnt});
    check_eq("sat_model", {16'd0, exp_cnt}, CNT_EN ? 32'h0000_FFFF : 32'h0000_0000);
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
